// File: rtl/univ_shift_reg_seq.sv
// univ_shift_reg_seq
//   Universal shift register with a start/busy/done handshake. An accepted
//   request latches op, amt and d, then the engine performs one step per
//   clock: load, clear, logical/arithmetic shift or rotate by one bit.
//
//   Optional feature macro: USR_FLAGS_EN adds the zero and carry outputs.
//
// Ports
//   clk      in   clock, all state changes on the rising edge
//   reset_n  in   synchronous active-low reset
//   start    in   request, accepted only while busy=0
//   op       in   3-bit opcode (NOP LOAD SLL SRL SRA ROL ROR CLR)
//   amt      in   step count for shift/rotate ops
//   d        in   parallel load data, captured on accept
//   si       in   serial input, sampled on every SLL/SRL step
//   q        out  register contents
//   so       out  last bit shifted or rotated out
//   busy     out  operation in progress
//   done     out  one-cycle completion pulse
//   zero     out  (USR_FLAGS_EN) registered q==0
//   carry    out  (USR_FLAGS_EN) OR of bits shifted out by SLL/SRL/SRA
module univ_shift_reg_seq #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] d,
  input  logic             si,
  output logic [WIDTH-1:0] q,
  output logic             so,
  output logic             busy,
  output logic             done
`ifdef USR_FLAGS_EN
  ,
  output logic             zero,
  output logic             carry
`endif
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_SRL  = 3'b011;
  localparam logic [2:0] OP_SRA  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_ROR  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_d;
  logic [2:0]       op_l;
  logic [AMT_W-1:0] cnt;
  logic [WIDTH-1:0] d_l;
  logic             accept, last;
  logic             is_shift;
  logic [WIDTH-1:0] step_q;
  logic             step_so;

  // One bit-serial step; returns {so, q}.
  function automatic logic [WIDTH:0] step_fn(
    input logic [2:0]       o,
    input logic [WIDTH-1:0] cur,
    input logic             cur_so,
    input logic [WIDTH-1:0] dl,
    input logic             s
  );
    logic [WIDTH:0] r;
    r = {cur_so, cur};
    case (o)
      OP_LOAD: r = {1'b0, dl};
      OP_CLR:  r = '0;
      OP_SLL:  r = {cur[WIDTH-1], cur[WIDTH-2:0], s};
      OP_SRL:  r = {cur[0], s, cur[WIDTH-1:1]};
      OP_SRA:  r = {cur[0], cur[WIDTH-1], cur[WIDTH-1:1]};
      OP_ROL:  r = {cur[WIDTH-1], cur[WIDTH-2:0], cur[WIDTH-1]};
      OP_ROR:  r = {cur[0], cur[0], cur[WIDTH-1:1]};
      default: r = {cur_so, cur};
    endcase
    return r;
  endfunction

  assign is_shift = (op >= OP_SLL) && (op <= OP_ROR);
  assign busy     = (state == RUN);
  assign {step_so, step_q} = step_fn(op_l, q, so, d_l, si);

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    last    = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept  = 1'b1;
        state_d = RUN;
      end
      RUN: if (cnt == AMT_W'(1)) begin
        last    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      done <= 1'b0;
      cnt  <= '0;
      op_l <= OP_NOP;
      q    <= '0;
      so   <= 1'b0;
    end else begin
      done <= last;
      if (accept) begin
        // A zero-step shift/rotate still takes one cycle but must not
        // touch q or so, so it is run as a NOP.
        if (is_shift && amt == '0) begin
          op_l <= OP_NOP;
          cnt  <= AMT_W'(1);
        end else begin
          op_l <= op;
          cnt  <= is_shift ? amt : AMT_W'(1);
        end
      end else if (state == RUN) begin
        cnt <= cnt - AMT_W'(1);
        q   <= step_q;
        so  <= step_so;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) d_l <= d;
  end

`ifdef USR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      zero  <= 1'b1;
      carry <= 1'b0;
    end else if (accept) begin
      carry <= 1'b0;
    end else if (state == RUN) begin
      zero <= (step_q == '0);
      if (op_l == OP_SLL || op_l == OP_SRL || op_l == OP_SRA)
        carry <= carry | step_so;
    end
  end
`endif

endmodule

// File: tb/tb_univ_shift_reg_seq.sv
// Testbench for univ_shift_reg_seq (WIDTH=8): directed scenarios followed by
// randomized operations, compared against a whole-operation reference model.
module tb_univ_shift_reg_seq;

  localparam int W = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [2:0]    op;
  logic [AW-1:0] amt;
  logic [W-1:0]  d;
  logic          si;
  logic [W-1:0]  q;
  logic          so, busy, done;
`ifdef USR_FLAGS_EN
  logic          zero, carry;
`endif

  int nchk  = 0;
  int nfail = 0;
  int mq    = 0;   // model register value
  int mso   = 0;   // model serial-out
  int mcar  = 0;   // model carry flag

  univ_shift_reg_seq #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .amt(amt),
    .d(d), .si(si), .q(q), .so(so), .busy(busy), .done(done)
`ifdef USR_FLAGS_EN
    , .zero(zero), .carry(carry)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_q"}, 32'(q), 32'(mq));
    chk({tag, "_so"}, 32'(so), 32'(mso));
`ifdef USR_FLAGS_EN
    chk({tag, "_zero"}, 32'(zero), 32'(mq == 0));
    chk({tag, "_carry"}, 32'(carry), 32'(mcar));
`endif
  endtask

  // Whole-operation reference: applies the op to mq/mso/mcar with plain arithmetic.
  task automatic model(input logic [2:0] o, input int a, input int dv, input int sis[$]);
    int v, r, orig, m;
    orig = mq;
    mcar = 0;
    if (o >= 2 && o <= 6 && a == 0) return;
    case (o)
      3'd1: begin mq = dv; mso = 0; end
      3'd7: begin mq = 0;  mso = 0; end
      3'd2: foreach (sis[i]) begin
              mso = (mq >> 7) & 1; mcar |= mso; mq = (mq * 2 + sis[i]) % 256;
            end
      3'd3: foreach (sis[i]) begin
              mso = mq % 2; mcar |= mso; mq = mq / 2 + sis[i] * 128;
            end
      3'd4: begin
              v   = (orig >= 128) ? orig - 256 : orig;
              mso = (a <= 8) ? (orig >> (a - 1)) & 1 : (orig >> 7) & 1;
              mq  = (v >>> a) & 255;
              m   = (a > 8) ? 8 : a;
              mcar = ((orig & ((1 << m) - 1)) != 0) ? 1 : 0;
            end
      3'd5: begin r = a % 8; mq = ((orig << r) | (orig >> (8 - r))) & 255; mso = mq & 1; end
      3'd6: begin r = a % 8; mq = ((orig >> r) | (orig << (8 - r))) & 255; mso = (mq >> 7) & 1; end
      default: ;
    endcase
  endtask

  // Issue one op and follow it to done. si_fix<0 means random si per step.
  // b2b=1 issues start in the current (done) cycle without waiting.
  task automatic run_op(input logic [2:0] o, input int a, input int dv,
                        input int si_fix, input bit b2b, input string tag);
    int n;
    int sis[$];
    n = (o >= 2 && o <= 6 && a != 0) ? a : 1;
    if (!b2b) @(negedge clk);
    start = 1'b1; op = o; amt = AW'(a); d = W'(dv);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_busy0"}, 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      // A start while busy must be ignored, including a changed op.
      start = (i == 0);
      op    = 3'd7;
      amt   = AW'($urandom_range(0, 15));
      d     = W'($urandom);
      si    = (si_fix < 0) ? 1'($urandom) : 1'(si_fix);
      sis.push_back(int'(si));
      @(posedge clk);
      @(negedge clk);
      if (i < n - 1) begin
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_nodone"}, 32'(done), 32'd0);
      end
    end
    start = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    model(o, a, dv, sis);
    chk_state(tag);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; op = 3'd0; amt = '0; d = '0; si = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk_state("rst");
    reset_n = 1'b1;

    // Reset for two edges in the middle of a ROL amt=4.
    run_op(3'd1, 0, 8'h3C, -1, 1'b0, "ld3c");
    @(negedge clk);
    start = 1'b1; op = 3'd5; amt = 4'd4;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    @(negedge clk); reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    mq = 0; mso = 0; mcar = 0;
    chk("rolrst_busy", 32'(busy), 32'd0);
    chk("rolrst_done", 32'(done), 32'd0);
    chk_state("rolrst");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rolrst_nopulse", 32'(done), 32'd0);
    end

    // LOAD A5, done lasts one cycle.
    run_op(3'd1, 0, 8'hA5, -1, 1'b0, "ldA5");
    chk("ldA5_const", 32'(q), 32'hA5);
    @(negedge clk);
    chk("ldA5_donedrop", 32'(done), 32'd0);
    chk("ldA5_hold", 32'(q), 32'hA5);

    // SLL amt=3 si=1 from A5.
    run_op(3'd2, 3, 0, 1, 1'b0, "sll3");
    chk("sll3_const", 32'(q), 32'h2F);
    chk("sll3_so", 32'(so), 32'd1);

    // SRA amt=2 from 90, then SRL amt=0.
    run_op(3'd1, 0, 8'h90, -1, 1'b0, "ld90");
    run_op(3'd4, 2, 0, -1, 1'b0, "sra2");
    chk("sra2_const", 32'(q), 32'hE4);
    run_op(3'd3, 0, 0, -1, 1'b0, "srl0");
    chk("srl0_const", 32'(q), 32'hE4);

    // ROR amt=9 from 81, back-to-back CLR.
    run_op(3'd1, 0, 8'h81, -1, 1'b0, "ld81");
    run_op(3'd6, 9, 0, -1, 1'b0, "ror9");
    chk("ror9_const", 32'(q), 32'hC0);
    run_op(3'd7, 0, 0, -1, 1'b1, "clrb2b");
    chk("clrb2b_const", 32'(q), 32'h00);

    // SLL amt=5 from FF with reset at edge k+2, then LOAD 3C.
    run_op(3'd1, 0, 8'hFF, -1, 1'b0, "ldFF");
    @(negedge clk);
    start = 1'b1; op = 3'd2; amt = 4'd5; si = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    @(negedge clk); reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    mq = 0; mso = 0; mcar = 0;
    chk("sllrst_busy", 32'(busy), 32'd0);
    chk_state("sllrst");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("sllrst_nopulse", 32'(done), 32'd0);
    end
    run_op(3'd1, 0, 8'h3C, -1, 1'b0, "ld3c2");

    // Randomized operations against the reference model.
    for (int t = 0; t < 60; t++) begin
      run_op(3'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 255)), -1, 1'($urandom), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
